// File: rtl/hls_itofp_unit.sv
// hls_itofp_unit: integer to binary32 converter, RNE, 4-edge latency.
// Define ITOFP_UNSIGNED_EN to add the p_unsigned (UIToFP) mode port.
module hls_itofp_unit #(
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  output logic                ack,
  input  logic [IN_WIDTH-1:0] p0,
`ifdef ITOFP_UNSIGNED_EN
  input  logic                p_unsigned,
`endif
  output logic [31:0]         out
);

  localparam int W = IN_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    NORM,
    RND,
    DONE
  } state_t;

  state_t       state;
  logic [W-1:0] op;
  logic [W-1:0] mag;
  logic [W-1:0] norm;
  logic         sign;
  logic [7:0]   exp;

  logic         sgn_c;
  logic [W-1:0] mag_c;
  logic [6:0]   lz;
  logic [W-1:0] norm_c;
  logic [7:0]   exp_c;

  logic [W+25:0] ext;
  logic [22:0]   frac_raw;
  logic [22:0]   frac;
  logic          g_bit;
  logic          l_bit;
  logic          s_bit;
  logic          rnd;
  logic          cout;
  logic [7:0]    exp_r;
  logic          nz;

`ifdef ITOFP_UNSIGNED_EN
  logic umode;
  assign sgn_c = ~umode & op[W-1];
`else
  assign sgn_c = op[W-1];
`endif

  // Two's-complement magnitude; the most negative value maps to 100..0.
  assign mag_c = sgn_c ? -op : op;

  // Leading-zero count of the magnitude; W when the magnitude is zero.
  always_comb begin
    lz = 7'(W);
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lz = 7'(W - 1 - i);
    end
  end

  assign norm_c = mag << lz;
  assign exp_c  = 8'(126 + W) - {1'b0, lz};

  // Zero-pad on the right so narrow widths get G=S=0.
  assign ext      = {norm, 26'd0};
  assign nz       = ext[W+25];
  assign frac_raw = ext[W+24 -: 23];
  assign l_bit    = ext[W+2];
  assign g_bit    = ext[W+1];
  assign s_bit    = |ext[W:0];
  assign rnd      = g_bit & (l_bit | s_bit);

  // Carry out of the fraction leaves it zero and bumps the exponent.
  assign {cout, frac} = {1'b0, frac_raw} + 24'(rnd);
  assign exp_r        = exp + 8'(cout);

  // Conversion sequencer with registered ack/out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op    <= '0;
      mag   <= '0;
      norm  <= '0;
      sign  <= 1'b0;
      exp   <= '0;
      ack   <= 1'b0;
      out   <= '0;
`ifdef ITOFP_UNSIGNED_EN
      umode <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (req) begin
            op    <= p0;
`ifdef ITOFP_UNSIGNED_EN
            umode <= p_unsigned;
`endif
            state <= CAPT;
          end else begin
            state <= IDLE;
          end
        end
        CAPT: begin
          sign  <= sgn_c;
          mag   <= mag_c;
          state <= NORM;
        end
        NORM: begin
          norm  <= norm_c;
          exp   <= exp_c;
          state <= RND;
        end
        RND: begin
          out   <= nz ? {sign, exp_r, frac} : 32'h0;
          ack   <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_itofp_unit.sv
// tb_hls_itofp_unit: directed vectors for hls_itofp_unit.
// Covers 32-, 64- and 8-bit operand widths.
module tb_hls_itofp_unit;

  logic        clk;
  logic        reset;
  logic        req32, req64, req8;
  logic        ack32, ack64, ack8;
  logic [31:0] p32;
  logic [63:0] p64;
  logic [7:0]  p8;
  logic        pu32, pu64, pu8;
  logic [31:0] out32, out64, out8;

  int nvec;
  int nerr;

  hls_itofp_unit #(.IN_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .req(req32), .ack(ack32),
    .p0(p32),
`ifdef ITOFP_UNSIGNED_EN
    .p_unsigned(pu32),
`endif
    .out(out32)
  );

  hls_itofp_unit #(.IN_WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .req(req64), .ack(ack64),
    .p0(p64),
`ifdef ITOFP_UNSIGNED_EN
    .p_unsigned(pu64),
`endif
    .out(out64)
  );

  hls_itofp_unit #(.IN_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .ack(ack8),
    .p0(p8),
`ifdef ITOFP_UNSIGNED_EN
    .p_unsigned(pu8),
`endif
    .out(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ack_of(input int w);
    if (w == 64) return ack64;
    if (w == 8) return ack8;
    return ack32;
  endfunction

  function automatic logic [31:0] out_of(input int w);
    if (w == 64) return out64;
    if (w == 8) return out8;
    return out32;
  endfunction

  // One conversion: lat counts edges from the accepting edge to ack.
  task automatic do_conv(input int w, input logic [63:0] v,
                         input logic u, output logic [31:0] res,
                         output int lat, output logic pulse_ok);
    @(negedge clk);
    case (w)
      64: begin req64 = 1'b1; p64 = v; pu64 = u; end
      8: begin req8 = 1'b1; p8 = v[7:0]; pu8 = u; end
      default: begin req32 = 1'b1; p32 = v[31:0]; pu32 = u; end
    endcase
    @(posedge clk);
    #1;
    req32 = 1'b0; req64 = 1'b0; req8 = 1'b0;
    p32 = 32'hDEADBEEF; p64 = 64'h0123456789ABCDEF; p8 = 8'h5A;
    lat = 1;
    while (!ack_of(w) && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_of(w);
    if (!ack_of(w)) lat = -1;
    @(posedge clk);
    #1;
    pulse_ok = !ack_of(w);
  endtask

  task automatic test_reset();
    nvec++;
    if (ack32 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ack: got %b want 0", ack32);
    end
    nvec++;
    if (out32 !== 32'h0) begin
      nerr++;
      $display("FAIL reset_out: got %h want 00000000", out32);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    int lat;
    logic pok;
    do_conv(32, 64'd1, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'h3F800000) begin
      nerr++;
      $display("FAIL basic_one: got %h want 3f800000", r);
    end
    nvec++;
    if (lat !== 4) begin
      nerr++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    nvec++;
    if (pok !== 1'b1) begin
      nerr++;
      $display("FAIL basic_ack_width: got %b want 1", pok);
    end
    do_conv(32, 64'hFFFFFFFF, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'hBF800000 || lat !== 4) begin
      nerr++;
      $display("FAIL basic_minus_one: got %h lat %0d want bf800000 lat 4",
               r, lat);
    end
  endtask

  task automatic test_special();
    logic [31:0] vin[7] = '{32'h0, 32'h80000000, 32'h7FFFFFFF,
                            32'd100, 32'd2, 32'd16777215, 32'hFFFFFF9C};
    logic [31:0] vex[7] = '{32'h0, 32'hCF000000, 32'h4F000000,
                            32'h42C80000, 32'h40000000, 32'h4B7FFFFF,
                            32'hC2C80000};
    logic [31:0] r;
    int lat;
    logic pok;
    for (int i = 0; i < 7; i++) begin
      do_conv(32, {32'h0, vin[i]}, 1'b0, r, lat, pok);
      nvec++;
      if (r !== vex[i] || lat !== 4) begin
        nerr++;
        $display("FAIL special_%0d: in %h got %h lat %0d want %h lat 4",
                 i, vin[i], r, lat, vex[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin[4] = '{32'd16777217, 32'd16777219, 32'd16777221,
                            32'd33554435};
    logic [31:0] vex[4] = '{32'h4B800000, 32'h4B800002, 32'h4B800002,
                            32'h4C000001};
    logic [31:0] r;
    int lat;
    logic pok;
    for (int i = 0; i < 4; i++) begin
      do_conv(32, {32'h0, vin[i]}, 1'b0, r, lat, pok);
      nvec++;
      if (r !== vex[i]) begin
        nerr++;
        $display("FAIL round_%0d: in %0d got %h want %h",
                 i, vin[i], r, vex[i]);
      end
    end
  endtask

  task automatic test_unsigned();
`ifdef ITOFP_UNSIGNED_EN
    logic [31:0] r;
    int lat;
    logic pok;
    do_conv(32, 64'hFFFFFFFF, 1'b1, r, lat, pok);
    nvec++;
    if (r !== 32'h4F800000) begin
      nerr++;
      $display("FAIL unsigned_32: got %h want 4f800000", r);
    end
    do_conv(32, 64'hFFFFFFFF, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'hBF800000) begin
      nerr++;
      $display("FAIL signed_mode_32: got %h want bf800000", r);
    end
    do_conv(64, 64'hFFFFFFFFFFFFFFFF, 1'b1, r, lat, pok);
    nvec++;
    if (r !== 32'h5F800000) begin
      nerr++;
      $display("FAIL unsigned_64: got %h want 5f800000", r);
    end
`endif
  endtask

  task automatic test_widths();
    logic [31:0] r;
    int lat;
    logic pok;
    do_conv(64, 64'hFFFFFFFFFFFFFFFF, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'hBF800000 || lat !== 4) begin
      nerr++;
      $display("FAIL w64_minus_one: got %h lat %0d want bf800000 lat 4",
               r, lat);
    end
    do_conv(64, 64'h8000000000000000, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'hDF000000) begin
      nerr++;
      $display("FAIL w64_most_neg: got %h want df000000", r);
    end
    do_conv(8, 64'h80, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'hC3000000 || lat !== 4) begin
      nerr++;
      $display("FAIL w8_most_neg: got %h lat %0d want c3000000 lat 4",
               r, lat);
    end
    do_conv(8, 64'h7F, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'h42FE0000) begin
      nerr++;
      $display("FAIL w8_max: got %h want 42fe0000", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[12] = '{32'd1, 32'd7, 32'd9, 32'd11,
                              32'hFFFFFFFF, 32'd3, 32'd5, 32'd13,
                              32'd100, 32'd15, 32'd17, 32'd19};
    logic [31:0] vex[3] = '{32'h3F800000, 32'hBF800000, 32'h42C80000};
    int nack;
    logic stray;
    nack = 0;
    stray = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req32 = 1'b1;
      p32 = vals[c];
      @(posedge clk);
      #1;
      if (ack32) nack++;
      if (c % 4 == 3) begin
        nvec++;
        if (ack32 !== 1'b1 || out32 !== vex[c/4]) begin
          nerr++;
          $display("FAIL b2b_result_%0d: ack %b out %h want ack 1 out %h",
                   c / 4, ack32, out32, vex[c/4]);
        end
      end else if (ack32 !== 1'b0) begin
        stray = 1'b1;
      end
    end
    @(negedge clk);
    req32 = 1'b0;
    nvec++;
    if (nack !== 3 || stray !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_ack_count: got %0d stray %b want 3 stray 0",
               nack, stray);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    logic [31:0] r;
    int lat;
    logic pok;
    @(negedge clk);
    req32 = 1'b1;
    p32 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    nvec++;
    if (out32 !== 32'h0 || ack32 !== 1'b0) begin
      nerr++;
      $display("FAIL abort_clear: out %h ack %b want 00000000 ack 0",
               out32, ack32);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack32) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL abort_no_ack: got ack %b want 0", seen);
    end
    @(negedge clk);
    reset = 1'b0;
    req32 = 1'b1;
    p32 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req32 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ack32) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++;
      $display("FAIL reset_beats_req: got ack %b want 0", seen);
    end
    do_conv(32, 64'd2, 1'b0, r, lat, pok);
    nvec++;
    if (r !== 32'h40000000 || lat !== 4) begin
      nerr++;
      $display("FAIL after_abort: got %h lat %0d want 40000000 lat 4",
               r, lat);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    req32 = 1'b0; req64 = 1'b0; req8 = 1'b0;
    p32 = '0; p64 = '0; p8 = '0;
    pu32 = 1'b0; pu64 = 1'b0; pu8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_basic();
    test_special();
    test_rounding();
    test_unsigned();
    test_widths();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hls_itofp_unit.md
# hls_itofp_unit

Parametrised integer-to-single-precision converter for the HLS backend. Accepts an IN_WIDTH-bit integer on a req/ack handshake and returns an IEEE-754 binary32 result after a fixed 4-edge latency, using round-to-nearest-even. Replaces the fixed 32-bit signed wrapper. The block uses its own internal state machine, not a free-running pipeline plus tick counter. It is instantiated per SIToFP/UIToFP call site by the HLS scheduler.

## Interface
- IN_WIDTH, 32, integer operand width, legal range 8..64
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; clears state and outputs on the edge where reset=0
- req  in  1  level request; sampled only in IDLE or DONE
- ack  out  1  one-cycle completion pulse; out valid while ack=1
- p0  in  IN_WIDTH  integer operand, sampled on the accepting edge only
- p_unsigned  in  1  present only with ITOFP_UNSIGNED_EN; 1 = treat p0 as unsigned, sampled with p0
- out  out  32  binary32 result

## Operation
- States: IDLE, CAPT, NORM, RND, DONE.
- IDLE: if req=1, register p0 (and mode); go to CAPT.
- CAPT: sign = MSB of p0 when signed, else 0; mag = sign ? -p0 : p0, as unsigned IN_WIDTH bits. The most negative value yields 100..0, which is correct. Go to NORM.
- NORM: lz = leading-zero count of mag. Shift mag left by lz so the leading 1 sits at the MSB. exp = 127 + IN_WIDTH-1-lz. zero flag = (mag==0). Go to RND.
- RND: take 24 significant bits from the normalised value (LSB L), guard G = next bit, sticky S = OR of all remaining bits. If IN_WIDTH ≤ 24, zero-pad on the right, so G=S=0.
  - Round up iff G & (L|S).
  - Mantissa carry-out: fraction becomes 0 and exp increments.
  - Register out = {sign, exp[7:0], frac[22:0]}; zero gives 0x00000000 (never -0).
  - Go to DONE.
- DONE: ack=1. If req=1, re-accept the current p0 and go to CAPT (back-to-back); else go to IDLE.
- Overflow, NaN and denormal cannot occur for IN_WIDTH ≤ 64 and need no logic.

## Timing
- Reset values: state=IDLE, ack=0, out=32'h0. All internal registers are cleared.
- Latency:
  - req sampled high at edge N.
  - ack high in the cycle after edge N+3, for exactly one cycle.
  - out is updated at edge N+3 and stays stable until the RND edge of the next operation.
- Throughput: one result per 4 cycles when req stays high.
- The caller must drop req in the ack cycle, or a new conversion of the current p0 starts.
- req during CAPT/NORM/RND is ignored; p0 changes after the accepting edge are ignored.
- reset=0 mid-operation: abort on that edge, no ack, out=0, state=IDLE.
- reset=0 and req=1 on the same edge: reset wins.

## Configuration
- ITOFP_UNSIGNED_EN defined: p_unsigned port exists. With p_unsigned=1, sign=0 and mag=p0 (UIToFP).
- ITOFP_UNSIGNED_EN undefined: no p_unsigned port; the operand is always signed (SIToFP).

## Test plan
- IN_WIDTH=32, p0=1, then p0=-1 -> out=0x3F800000, then 0xBF800000. ack is exactly one cycle, 4 edges after req.
- p0=0 -> out=0x00000000. p0=0x80000000 -> 0xCF000000. p0=0x7FFFFFFF -> 0x4F000000 (round-up carry into exponent).
- Rounding: p0=16777217 -> 0x4B800000 (tie, to even). p0=16777219 -> 0x4B800002 (tie, up). p0=16777221 -> 0x4B800002 (tie, to even).
- ITOFP_UNSIGNED_EN, p_unsigned=1, p0=0xFFFFFFFF -> 0x4F800000. Same p0 with p_unsigned=0 -> 0xBF800000.
- req held high for 12 cycles with p0 changing each cycle -> three acks 4 cycles apart, each result matching the p0 present at its accepting edge. Then drive reset=0 in NORM -> no ack, out=0, IDLE.
- IN_WIDTH=64, p0=0xFFFFFFFFFFFFFFFF signed -> 0xBF800000. Unsigned build -> 0x5F800000. IN_WIDTH=8, p0=8'h80 -> 0xC3000000.
